mem_port_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch requester (inst_sram_*) and the load/store requester (data_sram_*).
- Sits between the pipeline stages and the single memory/bridge port.
- Keeps one transaction in flight at a time and routes each response back to the requester that issued it.
- Data side has fixed priority, with a starvation guard that forces an instruction grant.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_req_mux.sv | 12 +
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and request bundle for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2} state_e;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/mem_port_arbiter_req_mux.sv
// mem_port_arbiter_req_mux: selects the owner's request fields, zeroed outside the address phase
module mem_port_arbiter_req_mux
  import mem_port_arbiter_pkg::*;
(
  input  owner_e    owner,
  input  logic      en,
  input  sram_req_t inst_req,
  input  sram_req_t data_req,
  output sram_req_t mem_req
);
  assign mem_req = !en ? '0 : owner == OWN_DATA ? data_req : inst_req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sram-like port between fetch and load/store, one transaction in flight,
// data-side priority with a starvation guard that forces an instruction grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              at_limit, grant_inst, in_addr, in_wait;
  sram_req_t         mux_out;
  assign at_limit   = cnt_q == CNT_W'(STARVE_LIMIT);
  assign grant_inst = inst_sram_req && (!data_sram_req || at_limit);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (inst_sram_req || data_sram_req) begin
        state_d = ADDR;
        owner_d = grant_inst ? OWN_INST : OWN_DATA;
        cnt_d   = (grant_inst || !inst_sram_req) ? '0 : at_limit ? cnt_q : cnt_q + 1'b1;
      end
      ADDR: state_d = mem_addr_ok ? WAIT : ADDR;
      WAIT: state_d = mem_data_ok ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_addr = state_q == ADDR;
  assign in_wait = state_q == WAIT;
  mem_port_arbiter_req_mux u_req_mux (
    .owner    (owner_q),
    .en       (in_addr),
    .inst_req ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata}),
    .data_req ({data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}),
    .mem_req  (mux_out)
  );
  assign mem_req   = in_addr;
  assign mem_wr    = mux_out.wr;
  assign mem_size  = mux_out.size;
  assign mem_wstrb = mux_out.wstrb;
  assign mem_addr  = mux_out.addr;
  assign mem_wdata = mux_out.wdata;
  // Responses only route during WAIT, so stray slave data_ok pulses never reach a requester.
  assign inst_sram_addr_ok = in_addr && owner_q == OWN_INST && mem_addr_ok;
  assign data_sram_addr_ok = in_addr && owner_q == OWN_DATA && mem_addr_ok;
  assign inst_sram_data_ok = in_wait && owner_q == OWN_INST && mem_data_ok;
  assign data_sram_data_ok = in_wait && owner_q == OWN_DATA && mem_data_ok;
  assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : '0;
  assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a grant/response scoreboard checked by a negedge monitor
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 1'b0, resetn;
  logic inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
  logic [1:0] inst_sram_size, data_sram_size, mem_size;
  logic [3:0] inst_sram_wstrb, data_sram_wstrb, mem_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
  logic inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [139:0] all_out;

  typedef struct packed {logic own; logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] addr; logic [31:0] wdata;} grant_t;
  typedef struct packed {logic own; logic [31:0] rdata;} resp_t;
  grant_t gq[$];
  resp_t  rq[$];
  grant_t g;
  resp_t  r;
  int checks = 0, errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  assign all_out = {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, inst_sram_addr_ok, inst_sram_data_ok,
                    data_sram_addr_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_sram_req = req; inst_sram_wr = 1'b0; inst_sram_size = SIZE_WORD;
    inst_sram_wstrb = 4'h0; inst_sram_addr = addr; inst_sram_wdata = 32'h0;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_req = req; data_sram_wr = wr; data_sram_size = size;
    data_sram_wstrb = wstrb; data_sram_addr = addr; data_sram_wdata = wdata;
  endtask

  task automatic exp_grant(input logic own, input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                           input logic [31:0] addr, input logic [31:0] wdata);
    gq.push_back({own, wr, size, wstrb, addr, wdata});
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("mem_req_seen", 160'(mem_req), 160'(1));
  endtask

  // Slave: accept after adly stall cycles, answer on the following cycle.
  task automatic serve(input logic own, input int adly, input logic [31:0] rd, input bit drop);
    wait_req();
    repeat (adly) tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    if (drop) begin
      if (own) data_sram_req = 1'b0;
      else inst_sram_req = 1'b0;
    end
    mem_data_ok = 1'b1;
    mem_rdata = rd;
    rq.push_back({own, rd});
    tick();
    mem_data_ok = 1'b0;
    mem_rdata = 32'h0;
  endtask

  always @(negedge clk) begin
    if (mem_req && mem_addr_ok) begin
      chk("grant_pending", 160'(gq.size() != 0), 160'(1));
      if (gq.size() != 0) begin
        g = gq.pop_front();
        chk("grant", 160'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, inst_sram_addr_ok, data_sram_addr_ok}),
            160'({g.wr, g.size, g.wstrb, g.addr, g.wdata, !g.own, g.own}));
      end
    end else if (inst_sram_addr_ok || data_sram_addr_ok) begin
      chk("spurious_addr_ok", 160'({inst_sram_addr_ok, data_sram_addr_ok}), 160'(0));
    end
    if (rq.size() != 0 || inst_sram_data_ok || data_sram_data_ok) begin
      chk("resp_pending", 160'(rq.size() != 0), 160'(1));
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("resp", 160'({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata}),
            160'({!r.own, r.own, r.own ? 32'h0 : r.rdata, r.own ? r.rdata : 32'h0}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (2) tick();
    chk("reset_outputs", 160'(all_out), 160'(0));
    resetn = 1'b1;
    tick();
    // single instruction read
    exp_grant(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h1c000000, 32'h0);
    set_inst(1'b1, 32'h1c000000);
    serve(1'b0, 2, 32'h02800c0c, 1'b1);
    tick();
    chk("idle_after_inst", 160'(mem_req), 160'(0));
    // simultaneous: data first, inst next
    exp_grant(1'b1, 1'b1, SIZE_WORD, 4'hf, 32'h00000100, 32'hdeadbeef);
    exp_grant(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h1c000004, 32'h0);
    set_inst(1'b1, 32'h1c000004);
    set_data(1'b1, 1'b1, SIZE_WORD, 4'hf, 32'h00000100, 32'hdeadbeef);
    serve(1'b1, 0, 32'h0, 1'b1);
    serve(1'b0, 0, 32'h11111111, 1'b1);
    // starvation: four data grants, then inst forced, then the still-pending data
    for (int i = 0; i < 4; i++) exp_grant(1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h00000200, 32'h0);
    exp_grant(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h1c000008, 32'h0);
    exp_grant(1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h00000200, 32'h0);
    set_inst(1'b1, 32'h1c000008);
    set_data(1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h00000200, 32'h0);
    for (int i = 0; i < 4; i++) serve(1'b1, 0, 32'h100 + 32'(i), 1'b0);
    serve(1'b0, 0, 32'h22222222, 1'b1);
    serve(1'b1, 0, 32'h33333333, 1'b1);
    chk("starve_cnt_cleared", 160'(dut.cnt_q), 160'(0));
    // backpressure: request held for 10 stalled cycles
    exp_grant(1'b1, 1'b1, SIZE_HALF, 4'h3, 32'h00000300, 32'hcafef00d);
    set_data(1'b1, 1'b1, SIZE_HALF, 4'h3, 32'h00000300, 32'hcafef00d);
    wait_req();
    for (int i = 0; i < 10; i++) begin
      chk("backpressure_hold", 160'({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, inst_sram_addr_ok, data_sram_addr_ok}),
          160'({1'b1, 1'b1, 2'd1, 4'h3, 32'h00000300, 32'hcafef00d, 2'b00}));
      tick();
    end
    serve(1'b1, 0, 32'h44444444, 1'b1);
    // spurious mem_data_ok in IDLE and in ADDR
    mem_data_ok = 1'b1; mem_rdata = 32'h00000bad;
    tick();
    chk("spurious_idle", 160'({mem_req, inst_sram_data_ok, data_sram_data_ok}), 160'(0));
    mem_data_ok = 1'b0;
    exp_grant(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h1c00000c, 32'h0);
    set_inst(1'b1, 32'h1c00000c);
    wait_req();
    mem_data_ok = 1'b1;
    #1;
    chk("spurious_addr_phase", 160'({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata}), 160'(0));
    tick();
    chk("still_addr_phase", 160'(mem_req), 160'(1));
    mem_data_ok = 1'b0; mem_rdata = 32'h0;
    serve(1'b0, 0, 32'h0badf00d, 1'b1);
    // reset while a data read is in WAIT
    exp_grant(1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h00000400, 32'h0);
    set_data(1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h00000400, 32'h0);
    wait_req();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; data_sram_req = 1'b0;
    resetn = 1'b0;
    #1;
    chk("reset_in_wait", 160'(all_out), 160'(0));
    tick();
    resetn = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'h55555555;
    tick();
    chk("late_data_ok_dropped", 160'({mem_req, inst_sram_data_ok, data_sram_data_ok, data_sram_rdata}), 160'(0));
    mem_data_ok = 1'b0; mem_rdata = 32'h0;
    exp_grant(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h1c000010, 32'h0);
    set_inst(1'b1, 32'h1c000010);
    serve(1'b0, 1, 32'h12345678, 1'b1);
    repeat (3) tick();
    chk("queues_drained", 160'({gq.size(), rq.size()}), 160'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
